axis_red_pitaya_dac_buf: RTL and testbench



---
 rtl/dac_pkg.sv | 30 +++
 rtl/axis_sync_fifo_simple.sv | 77 +++++++
 rtl/axis_red_pitaya_dac_buf.sv | 126 ++++++++++++
 tb/tb_axis_red_pitaya_dac_buf.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/dac_pkg.sv
// dac_pkg: shared types and helpers for the Red Pitaya DAC output path.
//   state_e     : playback control states (IDLE, FILL, RUN)
//   ZERO_CODE   : DAC code for a zero sample at the native 14-bit width
//   to_dac_code : two's complement sample -> DAC code (MSB kept, rest inverted)
package dac_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } state_e;

  localparam logic [13:0] ZERO_CODE = 14'h1FFF;

  // Only bits [w-1:0] of x are meaningful; everything above is returned as 0
  // so the caller can slice the low w bits without masking.
  function automatic logic [15:0] to_dac_code(input logic [15:0] x, input int w);
    logic [15:0] c;
    c = '0;
    for (int i = 0; i < 16; i++) begin
      if (i == w - 1) begin
        c[i] = x[i];
      end else if (i < w - 1) begin
        c[i] = ~x[i];
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/axis_sync_fifo_simple.sv
// axis_sync_fifo_simple: single-clock FIFO with a registered read port.
//   aclk, areset : clock and synchronous active-high reset
//   flush        : empties the FIFO on the next edge; beats written that cycle are dropped
//   wr_en/wr_data: write port (ignored while full)
//   rd_en/rd_data: read port; rd_data updates on the edge after rd_en and holds otherwise
//   count        : occupancy, full / empty flags
// A word written in cycle t is first readable in cycle t+1 (no write-through).
module axis_sync_fifo_simple #(
  parameter int WIDTH = 28,
  parameter int DEPTH = 8
) (
  input  logic                       aclk,
  input  logic                       areset,
  input  logic                       flush,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] rd_data_q;
  logic             do_wr;
  logic             do_rd;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign do_wr = wr_en && !full && !flush;
  assign do_rd = rd_en && !empty && !flush;

  // Storage is not reset; only the pointers and count define validity.
  always_ff @(posedge aclk) begin
    if (do_wr) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rd_data_q <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (do_rd) begin
        rd_ptr_q  <= rd_ptr_q + AW'(1);
        rd_data_q <= mem_q[rd_ptr_q];
      end
      if (do_wr && !do_rd) begin
        count_q <= count_q + CW'(1);
      end else if (!do_wr && do_rd) begin
        count_q <= count_q - CW'(1);
      end
    end
  end

  assign rd_data = rd_data_q;
  assign count   = count_q;

endmodule

// File: rtl/axis_red_pitaya_dac_buf.sv
// axis_red_pitaya_dac_buf: AXI4-Stream sink feeding the Red Pitaya DAC.
// Buffers packed {B,A} sample pairs, converts them to DAC code and plays one
// pair per aclk once PREFILL entries are queued; re-prefills after underrun.
//   aclk, areset        : clock (also DAC sample clock), sync active-high reset
//   enable              : playback enable; low flushes and idles the outputs
//   s_axis_tdata/tvalid/tready : stream input, A in [15:0], B in [31:16]
//   dac_dat_a/dac_dat_b : DAC codes
//   dac_valid           : codes come from a popped entry
//   running             : control FSM is in RUN
//   fifo_count          : FIFO occupancy
//   underrun_cnt        : saturating underrun event counter
module axis_red_pitaya_dac_buf
  import dac_pkg::*;
#(
  parameter int DAC_DATA_WIDTH   = 14,
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int FIFO_DEPTH       = 8,
  parameter int PREFILL          = 4,
  parameter int HOLD_LAST        = 1
) (
  input  logic                            aclk,
  input  logic                            areset,
  input  logic                            enable,
  input  logic [AXIS_TDATA_WIDTH-1:0]     s_axis_tdata,
  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  output logic [DAC_DATA_WIDTH-1:0]       dac_dat_a,
  output logic [DAC_DATA_WIDTH-1:0]       dac_dat_b,
  output logic                            dac_valid,
  output logic                            running,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
  output logic [15:0]                     underrun_cnt
);

  localparam int W  = DAC_DATA_WIDTH;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [15:0]  ZC16 = to_dac_code(16'd0, DAC_DATA_WIDTH);
  localparam logic [W-1:0] ZC   = ZC16[W-1:0];

  state_e          state_q, state_d;
  logic            dac_valid_q;
  logic            zero_q;
  logic [15:0]     underrun_q;

  logic [15:0]     code_a16, code_b16;
  logic [2*W-1:0]  fifo_rd_data;
  logic [CW-1:0]   fifo_cnt;
  logic            fifo_full, fifo_empty;
  logic            push, pop, underrun_ev;
  logic            unused_bits;

  // Conversion happens before the FIFO so the output side is just a mux
  // between the FIFO read register and the zero code.
  assign code_a16    = to_dac_code(s_axis_tdata[15:0], W);
  assign code_b16    = to_dac_code(s_axis_tdata[31:16], W);
  assign unused_bits = ^{code_a16[15:W], code_b16[15:W]};

  assign s_axis_tready = (state_q != IDLE) && !fifo_full;
  assign push          = s_axis_tvalid && s_axis_tready;
  assign pop           = enable && (state_q == RUN) && !fifo_empty;
  assign underrun_ev   = enable && (state_q == RUN) && fifo_empty;

  // flush dominates the write, so a beat handshaked while enable is low is dropped.
  axis_sync_fifo_simple #(
    .WIDTH (2*W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .aclk    (aclk),
    .areset  (areset),
    .flush   (!enable),
    .wr_en   (push),
    .wr_data ({code_b16[W-1:0], code_a16[W-1:0]}),
    .rd_en   (pop),
    .rd_data (fifo_rd_data),
    .count   (fifo_cnt),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    state_d = FILL;
        FILL:    if (fifo_cnt >= CW'(PREFILL)) state_d = RUN;
        RUN:     if (fifo_empty) state_d = FILL;
        default: state_d = IDLE;
      endcase
    end
  end

  // zero_q selects the zero code in place of the FIFO read register. The read
  // register only changes on a pop, so it naturally holds the last sample
  // through FILL and underruns.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q     <= IDLE;
      dac_valid_q <= 1'b0;
      zero_q      <= 1'b1;
      underrun_q  <= '0;
    end else begin
      state_q     <= state_d;
      dac_valid_q <= pop;
      if (!enable) begin
        zero_q <= 1'b1;
      end else if (pop) begin
        zero_q <= 1'b0;
      end else if (underrun_ev && (HOLD_LAST == 0)) begin
        zero_q <= 1'b1;
      end
      if (underrun_ev && (underrun_q != 16'hFFFF)) begin
        underrun_q <= underrun_q + 16'd1;
      end
    end
  end

  assign dac_dat_a    = zero_q ? ZC : fifo_rd_data[W-1:0];
  assign dac_dat_b    = zero_q ? ZC : fifo_rd_data[2*W-1:W];
  assign dac_valid    = dac_valid_q;
  assign running      = (state_q == RUN);
  assign fifo_count   = fifo_cnt;
  assign underrun_cnt = underrun_q;

endmodule

// File: tb/tb_axis_red_pitaya_dac_buf.sv
module tb_axis_red_pitaya_dac_buf;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        areset;
  // DUT 1: default parameters (PREFILL=4, HOLD_LAST=1)
  logic        en1, tv1, tr1, dv1, run1;
  logic [31:0] td1;
  logic [13:0] da1, db1;
  logic [3:0]  cnt1;
  logic [15:0] und1;
  // DUT 2: PREFILL=8, HOLD_LAST=0
  logic        en2, tv2, tr2, dv2, run2;
  logic [31:0] td2;
  logic [13:0] da2, db2;
  logic [3:0]  cnt2;
  logic [15:0] und2;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] tdata;
    logic [13:0] ea;
    logic [13:0] eb;
  } vec_t;
  vec_t vecs [8];

  axis_red_pitaya_dac_buf dut (
    .aclk(clk), .areset(areset), .enable(en1),
    .s_axis_tdata(td1), .s_axis_tvalid(tv1), .s_axis_tready(tr1),
    .dac_dat_a(da1), .dac_dat_b(db1), .dac_valid(dv1), .running(run1),
    .fifo_count(cnt1), .underrun_cnt(und1)
  );

  axis_red_pitaya_dac_buf #(.PREFILL(8), .HOLD_LAST(0)) dut2 (
    .aclk(clk), .areset(areset), .enable(en2),
    .s_axis_tdata(td2), .s_axis_tvalid(tv2), .s_axis_tready(tr2),
    .dac_dat_a(da2), .dac_dat_b(db2), .dac_valid(dv2), .running(run2),
    .fifo_count(cnt2), .underrun_cnt(und2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic chk_reset1(input string tag);
    chk({tag, " cnt"},    32'(cnt1), 32'd0);
    chk({tag, " tready"}, 32'(tr1),  32'd0);
    chk({tag, " run"},    32'(run1), 32'd0);
    chk({tag, " valid"},  32'(dv1),  32'd0);
    chk({tag, " dac_a"},  32'(da1),  32'h1FFF);
    chk({tag, " dac_b"},  32'(db1),  32'h1FFF);
    chk({tag, " und"},    32'(und1), 32'd0);
  endtask

  initial begin
    logic [13:0] ea, eb;

    vecs[0] = '{32'hFFFF_0000, 14'h1FFF, 14'h2000};  // A=0, B=-1
    vecs[1] = '{32'h0001_0001, 14'h1FFE, 14'h1FFE};
    vecs[2] = '{32'h0002_0002, 14'h1FFD, 14'h1FFD};
    vecs[3] = '{32'h0003_0003, 14'h1FFC, 14'h1FFC};
    vecs[4] = '{32'hE000_1FFF, 14'h0000, 14'h3FFF};  // A=+8191, B=-8192
    vecs[5] = '{32'hC002_DFFF, 14'h0000, 14'h1FFD};  // bits [15:14]=11 ignored
    vecs[6] = '{32'h7FFF_3FFF, 14'h2000, 14'h2000};  // -1 after dropping upper bits
    vecs[7] = '{32'h0004_0004, 14'h1FFB, 14'h1FFB};

    areset = 1'b1;
    en1 = 1'b0; tv1 = 1'b0; td1 = '0;
    en2 = 1'b0; tv2 = 1'b0; td2 = '0;
    step();
    step();
    chk_reset1("reset");
    chk("reset dut2 tready", 32'(tr2), 32'd0);
    areset = 1'b0;

    // ---- backpressure with PREFILL=8, then drain and HOLD_LAST=0 underrun
    en2 = 1'b1;
    step();
    tv2 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      td2 = {16'(20 + i), 16'(10 + i)};
      chk("bp tready open", 32'(tr2), 32'd1);
      step();
      chk("bp count", 32'(cnt2), 32'(i + 1));
    end
    td2 = 32'h0063_0063;
    chk("bp tready full", 32'(tr2), 32'd0);
    chk("bp not running", 32'(run2), 32'd0);
    step();
    tv2 = 1'b0;
    chk("bp run", 32'(run2), 32'd1);
    chk("bp count held", 32'(cnt2), 32'd8);
    chk("bp valid before pop", 32'(dv2), 32'd0);
    for (int i = 0; i < 8; i++) begin
      step();
      ea = 14'h1FFF - 14'(10 + i);
      eb = 14'h1FFF - 14'(20 + i);
      chk("bp drain valid", 32'(dv2), 32'd1);
      chk("bp drain a", 32'(da2), 32'(ea));
      chk("bp drain b", 32'(db2), 32'(eb));
      chk("bp drain count", 32'(cnt2), 32'(7 - i));
    end
    step();
    chk("ur0 valid", 32'(dv2), 32'd0);
    chk("ur0 run", 32'(run2), 32'd0);
    chk("ur0 und", 32'(und2), 32'd1);
    chk("ur0 dac_a zero", 32'(da2), 32'h1FFF);
    chk("ur0 dac_b zero", 32'(db2), 32'h1FFF);
    en2 = 1'b0;

    // ---- prefill, ordered playback, code conversion, HOLD_LAST=1 underrun
    en1 = 1'b1;
    step();
    chk("fill tready", 32'(tr1), 32'd1);
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < 4; i++) begin
        td1 = vecs[b*4 + i].tdata;
        tv1 = 1'b1;
        step();
        chk("fill count", 32'(cnt1), 32'(i + 1));
        chk("fill not running", 32'(run1), 32'd0);
        chk("fill valid", 32'(dv1), 32'd0);
        if (b == 1) chk("fill hold a", 32'(da1), 32'(vecs[3].ea));
      end
      tv1 = 1'b0;
      step();
      chk("run entered", 32'(run1), 32'd1);
      chk("run first cycle valid", 32'(dv1), 32'd0);
      for (int i = 0; i < 4; i++) begin
        step();
        chk("play valid", 32'(dv1), 32'd1);
        chk("play a", 32'(da1), 32'(vecs[b*4 + i].ea));
        chk("play b", 32'(db1), 32'(vecs[b*4 + i].eb));
        chk("play count", 32'(cnt1), 32'(3 - i));
      end
      step();
      chk("ur valid", 32'(dv1), 32'd0);
      chk("ur run", 32'(run1), 32'd0);
      chk("ur und", 32'(und1), 32'(b + 1));
      chk("ur hold a", 32'(da1), 32'(vecs[b*4 + 3].ea));
      chk("ur hold b", 32'(db1), 32'(vecs[b*4 + 3].eb));
    end

    // ---- enable dropped mid-RUN with 5 queued, push in flight discarded
    for (int i = 0; i < 5; i++) begin
      td1 = {16'd0, 16'(40 + i)};
      tv1 = 1'b1;
      step();
    end
    chk("dis run", 32'(run1), 32'd1);
    chk("dis count", 32'(cnt1), 32'd5);
    td1 = 32'h0000_0077;
    en1 = 1'b0;
    step();
    tv1 = 1'b0;
    chk("dis idle", 32'(run1), 32'd0);
    chk("dis count flushed", 32'(cnt1), 32'd0);
    chk("dis tready", 32'(tr1), 32'd0);
    chk("dis dac_a", 32'(da1), 32'h1FFF);
    chk("dis dac_b", 32'(db1), 32'h1FFF);
    chk("dis valid", 32'(dv1), 32'd0);
    chk("dis und kept", 32'(und1), 32'd2);
    step();
    chk("dis stays empty", 32'(cnt1), 32'd0);

    // ---- reset asserted during RUN
    en1 = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      td1 = {16'd0, 16'(50 + i)};
      tv1 = 1'b1;
      step();
    end
    tv1 = 1'b0;
    step();
    step();
    chk("rst pre valid", 32'(dv1), 32'd1);
    chk("rst pre a", 32'(da1), 32'h1FCD);
    areset = 1'b1;
    step();
    chk_reset1("midreset");
    areset = 1'b0;
    en1 = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
